// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and helpers for the button conditioner.
//                - NUM_BTNS    : default number of button channels.
//                - btn_idx_e   : channel index names (left/right/shoot).
//                - rep_state_e : auto-repeat FSM states.
//                - btn_clog2   : counter width helper, never below 1 bit.
//                Optional feature macro used by the consumers of this package:
//                BTN_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam int NUM_BTNS = 3;

    typedef enum logic [1:0] {
        BTN_LEFT  = 2'd0,
        BTN_RIGHT = 2'd1,
        BTN_SHOOT = 2'd2
    } btn_idx_e;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    // Width needed to hold values 0..n-1, with a floor of one bit.
    function automatic int btn_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One button channel: 2-flop synchroniser, counter-based
//                debounce, registered press/release strobes and, when the
//                macro BTN_AUTOREPEAT_EN is defined, an auto-repeat FSM that
//                adds extra press pulses while the button is held.
//  Ports       : clk        - system clock
//                rst        - synchronous active-high reset
//                btn_raw_i  - asynchronous pad level, 1 = pressed
//                level_o    - debounced level
//                press_o    - one-cycle strobe on debounced 0->1 (and repeat)
//                release_o  - one-cycle strobe on debounced 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             w_flip;
    logic             w_rep_pulse;

    // ------------------------------------------------------------------
    // Debounce: the counter only advances while the synchronised input
    // disagrees with the stable level; any agreement restarts it at 0.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        w_flip  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            w_flip  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = btn_clog2(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    rep_state_e       rep_state_q;
    rep_state_e       rep_state_d;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;

    // Looking at level_d rather than level_q means the FSM drops to idle
    // in the same cycle the release strobe fires, so a repeat pulse can
    // never coincide with a release.
    always_comb begin
        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        w_rep_pulse = 1'b0;
        if (!level_d) begin
            rep_state_d = REP_IDLE;
            rep_cnt_d   = '0;
        end else begin
            case (rep_state_q)
                REP_IDLE: begin
                    if (w_flip) begin
                        rep_state_d = REP_DELAY;
                        rep_cnt_d   = '0;
                    end
                end
                REP_DELAY: begin
                    if (rep_cnt_q == DELAY_LAST) begin
                        rep_state_d = REP_REPEAT;
                        rep_cnt_d   = '0;
                        w_rep_pulse = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                REP_REPEAT: begin
                    if (rep_cnt_q == PERIOD_LAST) begin
                        rep_cnt_d   = '0;
                        w_rep_pulse = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                default: begin
                    rep_state_d = REP_IDLE;
                    rep_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_state_q <= REP_IDLE;
            rep_cnt_q   <= '0;
        end else begin
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`else
    // Repeat timing has no meaning without the repeat FSM.
    logic w_unused_rep_cfg;
    assign w_unused_rep_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign w_rep_pulse      = 1'b0;
`endif

    // Strobes are registered alongside the level so they line up with
    // the first cycle the new level is visible.
    always_comb begin
        press_d   = (w_flip & sync2_q) | w_rep_pulse;
        release_d = w_flip & ~sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Conditions the raw pad buttons (left, right, shoot) for the
//                game core: per channel synchronise, debounce and produce a
//                clean level plus one-cycle press/release strobes.
//                Optional auto-repeat of press strobes: BTN_AUTOREPEAT_EN.
//  Ports       : clk         - system clock (pixel clock domain)
//                rst         - synchronous active-high reset
//                btn_raw     - asynchronous button levels, 1 = pressed
//                btn_level   - debounced levels
//                btn_press   - one-cycle press strobes
//                btn_release - one-cycle release strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int NUM_BTNS        = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    // Channels share nothing but the clock and reset.
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Self-checking bench for btn_conditioner with
//                DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
//                Stimulus queues the expected strobe events; a monitor pops
//                and compares them whenever the DUT raises a strobe.
//                Auto-repeat checks are active when BTN_AUTOREPEAT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int NB = 3;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int       cyc;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lvl;
    } exp_t;

    exp_t exp_q[$];

    btn_conditioner #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void expect_ev(input int cyc, input logic [2:0] p,
                                      input logic [2:0] r, input logic [2:0] l);
        exp_t e;
        e.cyc   = cyc;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        exp_q.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: expected press=%b release=%b at edge %0d, no strobe observed",
                     e.press, e.rel, e.cyc);
        end
        if ((|(btn_press | btn_release)) === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: press=%b release=%b at edge %0d, none expected",
                         btn_press, btn_release, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != edge_cnt || e.press !== btn_press ||
                    e.rel !== btn_release || e.lvl !== btn_level) begin
                    errors++;
                    $display("FAIL strobe_event: got edge %0d press=%b release=%b level=%b, expected edge %0d press=%b release=%b level=%b",
                             edge_cnt, btn_press, btn_release, btn_level,
                             e.cyc, e.press, e.rel, e.lvl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int p;
        rst     = 1'b1;
        btn_raw = 3'b111;

        // Reset with all buttons pressed: outputs held at 0.
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {btn_level, btn_press, btn_release}, 9'd0);
        end
        rst = 1'b0;
        e0  = edge_cnt;
        expect_ev(e0 + 10, 3'b111, 3'b000, 3'b111);
        step(9);
        check("reset_level_early", {6'd0, btn_level}, 9'd0);
        step(1);
        btn_raw = 3'b000;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b000, 3'b111, 3'b000);
        step(12);

        // Clean press on shoot.
        btn_raw = 3'b100;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b100, 3'b000, 3'b100);
        step(9);
        check("press_level_early", {6'd0, btn_level}, 9'd0);
        step(1);
        btn_raw = 3'b000;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b000, 3'b100, 3'b000);
        step(12);

        // Bouncing press on left: 1,0,1,0 every 3 cycles, then hold.
        for (int t = 0; t < 4; t++) begin
            btn_raw[0] = ~t[0];
            step(3);
        end
        check("bounce_no_level", {6'd0, btn_level}, 9'd0);
        btn_raw[0] = 1'b1;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b001, 3'b000, 3'b001);
        step(10);

        // Release glitch: 5 cycles released, 1 pressed, then clean release.
        btn_raw[0] = 1'b0;
        step(5);
        btn_raw[0] = 1'b1;
        step(1);
        btn_raw[0] = 1'b0;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b000, 3'b001, 3'b000);
        step(9);
        check("glitch_level_held", {6'd0, btn_level}, 9'b000000001);
        step(13);

        // Reset in the middle of a debounce restarts the whole pipeline.
        btn_raw = 3'b001;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midreset_outputs", {btn_level, btn_press, btn_release}, 9'd0);
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b001, 3'b000, 3'b001);
        step(10);
        btn_raw = 3'b000;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b000, 3'b001, 3'b000);
        step(12);

        // Simultaneous press on left and right.
        btn_raw = 3'b011;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b011, 3'b000, 3'b011);
        step(10);
        btn_raw = 3'b000;
        e0 = edge_cnt;
        expect_ev(e0 + 10, 3'b000, 3'b011, 3'b000);
        step(12);

        // Long hold on right: auto-repeat pulses when enabled.
        btn_raw = 3'b010;
        e0 = edge_cnt;
        p  = e0 + 10;
        expect_ev(p, 3'b010, 3'b000, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 20; k < 70; k += 5)
            expect_ev(p + k, 3'b010, 3'b000, 3'b010);
`endif
        step(70);
        check("hold_level", {6'd0, btn_level}, 9'b000000010);
        btn_raw = 3'b000;
        expect_ev(p + 70, 3'b000, 3'b010, 3'b000);
        step(15);
`ifdef BTN_AUTOREPEAT_EN
        check("rep_fsm_idle", {7'd0, dut.g_ch[1].u_ch.rep_state_q}, {7'd0, btn_pkg::REP_IDLE});
`endif
        step(5);
        check("final_level", {6'd0, btn_level}, 9'd0);
        check("queue_drained", 9'(exp_q.size()), 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
